plot_scheduler: RTL and testbench



---
 rtl/display_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/plot_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_plot_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared display constants, scheduler state encoding and
// colour constants used by plot_scheduler and its round-robin arbiter.
//   SCREEN_W / SCREEN_H : visible VGA area in pixels
//   X_W / Y_W / COLOUR_W: default coordinate and colour widths
package display_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // Scheduler state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_SWEEP = S_SWEEP,
        ST_DONE  = S_DONE
    } state_e;

    // 3-bit RGB colours
    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_BLUE  = 3'b001;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;
    localparam logic [2:0] COLOUR_RED   = 3'b100;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner select for plot_scheduler.
//   clock, reset : system clock, synchronous active-high reset
//   req          : request vector
//   advance      : strobe; pointer moves to (owner+1) mod NUM_REQ
//   owner        : index of the requester that just completed
//   any          : at least one request is pending
//   winner       : first set req bit at or after the pointer (wrapping)
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [PTR_W-1:0]   owner,
    output logic               any,
    output logic [PTR_W-1:0]   winner
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] idx_s;

    // Winner select: scan from the farthest slot back towards the pointer so
    // that the slot closest to the pointer is the last (and winning) write.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_s = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
            if (req[idx_s]) begin
                any    = 1'b1;
                winner = idx_s;
            end else begin
                any    = any;
                winner = winner;
            end
        end
    end

    // Pointer update on completion of a command
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler: shares one VGA plot port between NUM_REQ rectangle-fill
// requesters. Round-robin arbitration, one pixel per clock, done pulse.
//   clock, reset        : system clock, synchronous active-high reset
//   req / req_x / req_y / req_w / req_h / req_colour : packed commands
//   grant, done, busy   : handshake and status (all registered)
//   vga_x, vga_y, vga_colour, vga_plot : pixel port (all registered)
// Optional build macro PLOT_SCHEDULER_CLIP_EN: suppress vga_plot for pixels
// outside SCREEN_W x SCREEN_H; otherwise coordinates wrap and all plot.
module plot_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = display_pkg::X_W,
    parameter int Y_W      = display_pkg::Y_W,
    parameter int COLOUR_W = display_pkg::COLOUR_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*X_W-1:0]      req_x,
    input  logic [NUM_REQ*Y_W-1:0]      req_y,
    input  logic [NUM_REQ*X_W-1:0]      req_w,
    input  logic [NUM_REQ*Y_W-1:0]      req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [X_W-1:0]              vga_x,
    output logic [Y_W-1:0]              vga_y,
    output logic [COLOUR_W-1:0]         vga_colour,
    output logic                        vga_plot
);
    import display_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [1:0]          state_r;
    logic [PTR_W-1:0]    owner_r;
    logic [X_W-1:0]      x_r, w_r, cx_r;
    logic [Y_W-1:0]      y_r, h_r, cy_r;
    logic [COLOUR_W-1:0] colour_r;
    logic [NUM_REQ-1:0]  grant_r, done_r;
    logic                busy_r, vga_plot_r;
    logic [X_W-1:0]      vga_x_r;
    logic [Y_W-1:0]      vga_y_r;
    logic [COLOUR_W-1:0] vga_colour_r;

    logic                any_s, advance_s, col_last_s, row_last_s, vis_s;
    logic [PTR_W-1:0]    win_s;
    logic [X_W-1:0]      sel_x_s, sel_w_s, nxt_cx_s, base_x_s, off_x_s, pix_x_s;
    logic [Y_W-1:0]      sel_y_s, sel_h_s, nxt_cy_s, base_y_s, off_y_s, pix_y_s;
    logic [COLOUR_W-1:0] sel_colour_s;

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
        one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign advance_s = (state_r == S_DONE);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (advance_s),
        .owner   (owner_r),
        .any     (any_s),
        .winner  (win_s)
    );

    // Owner's command fields, read straight off the request bus in LOAD
    assign sel_x_s      = req_x[owner_r*X_W +: X_W];
    assign sel_y_s      = req_y[owner_r*Y_W +: Y_W];
    assign sel_w_s      = req_w[owner_r*X_W +: X_W];
    assign sel_h_s      = req_h[owner_r*Y_W +: Y_W];
    assign sel_colour_s = req_colour[owner_r*COLOUR_W +: COLOUR_W];

    // Next pixel position; in LOAD the first pixel comes from the bus fields
    always_comb begin
        col_last_s = (cx_r == (w_r - X_W'(1)));
        row_last_s = (cy_r == (h_r - Y_W'(1)));
        if (col_last_s) begin
            nxt_cx_s = '0;
            nxt_cy_s = cy_r + Y_W'(1);
        end else begin
            nxt_cx_s = cx_r + X_W'(1);
            nxt_cy_s = cy_r;
        end
        if (state_r == S_LOAD) begin
            base_x_s = sel_x_s;
            base_y_s = sel_y_s;
            off_x_s  = '0;
            off_y_s  = '0;
        end else begin
            base_x_s = x_r;
            base_y_s = y_r;
            off_x_s  = nxt_cx_s;
            off_y_s  = nxt_cy_s;
        end
    end

`ifdef PLOT_SCHEDULER_CLIP_EN
    logic [X_W:0] sum_x_s;
    logic [Y_W:0] sum_y_s;
    assign sum_x_s = {1'b0, base_x_s} + {1'b0, off_x_s};
    assign sum_y_s = {1'b0, base_y_s} + {1'b0, off_y_s};
    assign vis_s   = (sum_x_s < (X_W+1)'(SCREEN_W)) && (sum_y_s < (Y_W+1)'(SCREEN_H));
    assign pix_x_s = sum_x_s[X_W-1:0];
    assign pix_y_s = sum_y_s[Y_W-1:0];
`else
    // Off-screen coordinates simply wrap
    assign pix_x_s = base_x_s + off_x_s;
    assign pix_y_s = base_y_s + off_y_s;
    assign vis_s   = 1'b1;
`endif

    // Scheduler FSM and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_IDLE;
            owner_r      <= '0;
            x_r          <= '0;
            y_r          <= '0;
            w_r          <= '0;
            h_r          <= '0;
            cx_r         <= '0;
            cy_r         <= '0;
            colour_r     <= '0;
            grant_r      <= '0;
            done_r       <= '0;
            busy_r       <= 1'b0;
            vga_x_r      <= '0;
            vga_y_r      <= '0;
            vga_colour_r <= '0;
            vga_plot_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r     <= '0;
                    vga_plot_r <= 1'b0;
                    if (any_s) begin
                        state_r <= S_LOAD;
                        owner_r <= win_s;
                        grant_r <= one_hot(win_s);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    x_r      <= sel_x_s;
                    y_r      <= sel_y_s;
                    w_r      <= sel_w_s;
                    h_r      <= sel_h_s;
                    colour_r <= sel_colour_s;
                    cx_r     <= '0;
                    cy_r     <= '0;
                    if ((sel_w_s == '0) || (sel_h_s == '0)) begin
                        state_r    <= S_DONE;
                        done_r     <= one_hot(owner_r);
                        vga_plot_r <= 1'b0;
                    end else begin
                        state_r      <= S_SWEEP;
                        vga_x_r      <= pix_x_s;
                        vga_y_r      <= pix_y_s;
                        vga_colour_r <= sel_colour_s;
                        vga_plot_r   <= vis_s;
                    end
                end
                S_SWEEP: begin
                    // cx_r/cy_r track the pixel currently on the port
                    if (col_last_s && row_last_s) begin
                        state_r    <= S_DONE;
                        done_r     <= one_hot(owner_r);
                        vga_plot_r <= 1'b0;
                    end else begin
                        cx_r         <= nxt_cx_s;
                        cy_r         <= nxt_cy_s;
                        vga_x_r      <= pix_x_s;
                        vga_y_r      <= pix_y_s;
                        vga_colour_r <= colour_r;
                        vga_plot_r   <= vis_s;
                    end
                end
                S_DONE: begin
                    state_r    <= S_IDLE;
                    done_r     <= '0;
                    grant_r    <= '0;
                    busy_r     <= 1'b0;
                    vga_plot_r <= 1'b0;
                end
                default: begin
                    state_r    <= S_IDLE;
                    done_r     <= '0;
                    grant_r    <= '0;
                    busy_r     <= 1'b0;
                    vga_plot_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign vga_plot   = vga_plot_r;

endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: self-checking bench for plot_scheduler. Expected pixels
// are pushed to a scoreboard queue when a command is issued and popped as
// vga_plot pulses. Honours PLOT_SCHEDULER_CLIP_EN in its pixel model.
module tb_plot_scheduler;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*XW-1:0]   req_x = '0;
    logic [N*YW-1:0]   req_y = '0;
    logic [N*XW-1:0]   req_w = '0;
    logic [N*YW-1:0]   req_h = '0;
    logic [N*CW-1:0]   req_colour = '0;
    logic [N-1:0]      grant, done;
    logic              busy, vga_plot;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_colour;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [N-1:0] done_acc = '0;
    logic [XW+YW+CW-1:0] exp_q[$];

    plot_scheduler #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_colour(req_colour),
        .grant(grant), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    task automatic set_cmd(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [XW-1:0] w, input logic [YW-1:0] h, input logic [CW-1:0] c);
        req_x[i*XW +: XW]      = x;
        req_y[i*YW +: YW]      = y;
        req_w[i*XW +: XW]      = w;
        req_h[i*YW +: YW]      = h;
        req_colour[i*CW +: CW] = c;
    endtask

    // Reference pixel model: row-major sweep, wrap or clip
    task automatic push_rect(input int x, input int y, input int w, input int h, input logic [CW-1:0] c);
        int px;
        int py;
        for (int r = 0; r < h; r++) begin
            for (int q = 0; q < w; q++) begin
                px = x + q;
                py = y + r;
`ifdef PLOT_SCHEDULER_CLIP_EN
                if (px < 160 && py < 120) exp_q.push_back({px[XW-1:0], py[YW-1:0], c});
`else
                exp_q.push_back({px[XW-1:0], py[YW-1:0], c});
`endif
            end
        end
    endtask

    // Advance one cycle, sample at the falling edge, score any plotted pixel
    task automatic tick();
        logic [XW+YW+CW-1:0] got;
        logic [XW+YW+CW-1:0] exp;
        @(negedge clock);
        cyc++;
        done_acc = done_acc | done;
        if (vga_plot) begin
            got = {vga_x, vga_y, vga_colour};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_extra cyc=%0d got x=%0d y=%0d c=%0d, none expected", cyc, vga_x, vga_y, vga_colour);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d", cyc,
                             vga_x, vga_y, vga_colour, exp[XW+YW+CW-1:YW+CW], exp[YW+CW-1:CW], exp[CW-1:0]);
                end
            end
        end
        checks++;
        if ($countones(grant) > 1) begin
            errors++;
            $display("FAIL grant_onehot cyc=%0d got %b", cyc, grant);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({grant, done, busy, vga_plot} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got grant=%b done=%b busy=%b plot=%b, want 0", grant, done, busy, vga_plot);
        end
        checks++;
        if ({vga_x, vga_y, vga_colour} !== '0) begin
            errors++;
            $display("FAIL reset_pix got x=%0d y=%0d c=%0d, want 0", vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        tick();
    endtask

    // Generic single-requester rectangle: grant at 1, done at w*h+2
    task automatic test_rect(input int i, input int x, input int y, input int w, input int h, input logic [CW-1:0] c);
        logic [N-1:0] mask;
        int done_cyc;
        mask = '0;
        mask[i] = 1'b1;
        done_cyc = w * h + 2;
        set_cmd(i, x[XW-1:0], y[YW-1:0], w[XW-1:0], h[YW-1:0], c);
        push_rect(x, y, w, h, c);
        cyc = 0;
        req = mask;
        for (int t = 1; t <= done_cyc; t++) begin
            tick();
            if (t == 1) begin
                checks++;
                if (grant !== mask || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rect_grant req%0d cyc=1 got grant=%b busy=%b, want %b 1", i, grant, busy, mask);
                end
            end
            if (t < done_cyc) begin
                checks++;
                if (done !== '0) begin
                    errors++;
                    $display("FAIL rect_early_done req%0d cyc=%0d got %b, want 000", i, t, done);
                end
            end else begin
                checks++;
                if (done !== mask || grant !== mask) begin
                    errors++;
                    $display("FAIL rect_done req%0d cyc=%0d got done=%b grant=%b, want %b", i, t, done, grant, mask);
                end
                req = '0;
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== '0 || done !== '0) begin
            errors++;
            $display("FAIL rect_idle req%0d got busy=%b grant=%b done=%b, want 0", i, busy, grant, done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rect_missing req%0d got %0d pixels unplotted, want 0", i, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_single();
        test_rect(0, 10, 20, 2, 2, 3'b100);
    endtask

    task automatic test_zero_size();
        test_rect(1, 50, 60, 0, 5, 3'b010);
    endtask

    task automatic test_clip();
        test_rect(2, 158, 119, 4, 2, 3'b011);
        test_rect(0, 254, 5, 4, 1, 3'b110);
    endtask

    task automatic test_back_to_back();
        int order [4];
        int k;
        int rearm;
        order = '{0, 1, 2, 0};
        k = 0;
        rearm = 0;
        set_cmd(0, 8'd1, 7'd1, 8'd1, 7'd1, 3'b001);
        set_cmd(1, 8'd2, 7'd2, 8'd1, 7'd1, 3'b010);
        set_cmd(2, 8'd3, 7'd3, 8'd1, 7'd1, 3'b100);
        push_rect(1, 1, 1, 1, 3'b001);
        push_rect(2, 2, 1, 1, 3'b010);
        push_rect(3, 3, 1, 1, 3'b100);
        push_rect(1, 1, 1, 1, 3'b001);
        req = 3'b111;
        for (int t = 0; t < 60 && k < 4; t++) begin
            tick();
            if (rearm == 1) begin
                req[0] = 1'b1;
                rearm = 0;
            end
            if (done != '0) begin
                checks++;
                if (done !== (3'b001 << order[k]) || grant !== done) begin
                    errors++;
                    $display("FAIL contention_order n=%0d got done=%b grant=%b, want done=%b", k, done, grant, 3'b001 << order[k]);
                end
                req = req & ~done;
                if (k == 0) rearm = 1;
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL contention_count got %0d done pulses, want 4", k);
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL contention_end got busy=%b pending=%0d, want 0 0", busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_sweep();
        set_cmd(0, 8'd30, 7'd40, 8'd4, 7'd4, 3'b101);
        set_cmd(2, 8'd70, 7'd70, 8'd1, 7'd1, 3'b111);
        for (int q = 0; q < 3; q++) exp_q.push_back({8'(30 + q), 7'd40, 3'b101});
        cyc = 0;
        done_acc = '0;
        req = 3'b001;
        repeat (4) tick();          // cycles 1..4, pixel 3 on the port at cycle 4
        reset = 1'b1;
        req = 3'b101;
        tick();
        checks++;
        if ({grant, done, busy, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, want 0",
                     grant, done, busy, vga_plot, vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        push_rect(30, 40, 4, 4, 3'b101);
        cyc = 0;
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL midreset_regrant got grant=%b, want 001", grant);
        end
        req = 3'b001;
        repeat (16) tick();         // cycles 2..17
        checks++;
        if (done_acc !== '0) begin
            errors++;
            $display("FAIL midreset_no_done got done seen=%b, want 000", done_acc);
        end
        tick();                     // cycle 18
        checks++;
        if (done !== 3'b001) begin
            errors++;
            $display("FAIL midreset_done got %b, want 001", done);
        end
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_end got busy=%b pending=%0d, want 0 0", busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_zero_size();
        test_clip();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
